// File: rtl/cmp_sched.sv
// Two-requester sequencer sharing one 4-bit comparator slice for WIDTH-bit unsigned compares, MSB nibble first.
// Optional CMP_SCHED_EARLY_EXIT_EN: leave CMP at the first differing nibble instead of scanning all nibbles.
module cmp_sched #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic [3:0]       cmp_a,
   output logic [3:0]       cmp_b,
   input  logic             cmp_lt,
   input  logic             cmp_gt,
   output logic             done0,
   output logic             done1,
   output logic             lt,
   output logic             gt,
   output logic             eq,
   output logic             busy
);

   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IW-1:0] IDX_TOP = IW'(NIB - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CMP  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic             last_grant;
   logic             owner;
   logic             grant_sel;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [IW-1:0]    idx;
   logic             res_lt;
   logic             res_gt;
   logic             nxt_lt;
   logic             nxt_gt;
   logic             cmp_exit;

   // On a tie the requester not granted last wins; a lone request wins outright.
   always_comb grant_sel = (req0 && req1) ? ~last_grant : req1;

   always_comb busy = (state != S_IDLE);

   always_comb begin
      cmp_a = '0;
      cmp_b = '0;
      if (state == S_CMP) begin
         for (int unsigned i = 0; i < NIB; i++) begin
            if (idx == IW'(i)) begin
               cmp_a = opa[4*i +: 4];
               cmp_b = opb[4*i +: 4];
            end
         end
      end
   end

   // First decision sticks; GT wins if the slice ever reports both.
   always_comb begin
      nxt_gt = res_gt | (~res_lt & ~res_gt & cmp_gt);
      nxt_lt = res_lt | (~res_lt & ~res_gt & ~cmp_gt & cmp_lt);
`ifdef CMP_SCHED_EARLY_EXIT_EN
      cmp_exit = nxt_gt | nxt_lt | (idx == '0);
`else
      cmp_exit = (idx == '0);
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         opa        <= '0;
         opb        <= '0;
         idx        <= '0;
         res_lt     <= 1'b0;
         res_gt     <= 1'b0;
         done0      <= 1'b0;
         done1      <= 1'b0;
         lt         <= 1'b0;
         gt         <= 1'b0;
         eq         <= 1'b0;
      end else begin
         done0 <= 1'b0;
         done1 <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req0 || req1) begin
                  owner      <= grant_sel;
                  last_grant <= grant_sel;
                  opa        <= grant_sel ? a1 : a0;
                  opb        <= grant_sel ? b1 : b0;
                  idx        <= IDX_TOP;
                  res_lt     <= 1'b0;
                  res_gt     <= 1'b0;
                  state      <= S_CMP;
               end
            end
            S_CMP: begin
               res_lt <= nxt_lt;
               res_gt <= nxt_gt;
               // done and result are registered on the exit edge so they coincide with DONE.
               if (cmp_exit) begin
                  state <= S_DONE;
                  done0 <= ~owner;
                  done1 <= owner;
                  lt    <= nxt_lt;
                  gt    <= nxt_gt;
                  eq    <= ~(nxt_lt | nxt_gt);
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/cmp_sched.md
# cmp_sched

Sequencer and arbiter that shares one external 4-bit magnitude comparator slice between two requesters and performs WIDTH-bit unsigned compares nibble by nibble, MSB nibble first. It sits in the 8-bit ALU beside the comparator slice. It drives the slice's a/b inputs, samples its LT/GT outputs and returns a registered LT/GT/EQ result to the winning requester with a one-cycle done pulse.

## Interface
- WIDTH, 8, operand width in bits; must be a multiple of 4, minimum 4; NIB = WIDTH/4
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  synchronous reset, active low
- req0  in  1  requester 0 compare request; level, held until done0
- a0, b0  in  WIDTH  requester 0 operands; sampled only at grant
- req1  in  1  requester 1 compare request; same rules as req0
- a1, b1  in  WIDTH  requester 1 operands
- cmp_a, cmp_b  out  4  nibble driven to the shared comparator slice
- cmp_lt, cmp_gt  in  1  comparator slice outputs; combinational from cmp_a/cmp_b
- done0, done1  out  1  one-cycle completion pulse to the owning requester
- lt, gt, eq  out  1  registered result of the last completed compare; exactly one high after the first completion
- busy  out  1  high in CMP and DONE

## Operation
- States: IDLE, CMP, DONE.
- IDLE: if req0 or req1 is high, grant one requester:
  - If only one request is high, grant that requester.
  - If both are high, grant the requester not granted last. The last-grant register resets to 1, so req0 wins the first tie.
  - On grant: latch the owner's a/b into opa/opb, record the owner, set idx = NIB-1, go to CMP.
- CMP: cmp_a = opa[4*idx+3:4*idx], cmp_b = opb[4*idx+3:4*idx]. Each cycle, sample cmp_lt/cmp_gt:
  - First nibble with cmp_gt=1: record result GT. First nibble with cmp_lt=1: record result LT. Results are never overwritten after the first decision.
  - Exit to DONE when a decision is made (early exit, see Configuration) or when idx==0. If no decision was made by idx==0, the result is EQ.
  - Otherwise idx decrements by 1.
- DONE: the owner's done pulses high for one cycle. lt/gt/eq update in the same cycle and hold until the next DONE. Then return to IDLE.
- Request handling:
  - A requester that keeps req high after done is re-arbitrated in IDLE like any other request.
  - Dropping req mid-operation does not abort the compare; done still pulses.
  - Operand changes after grant are ignored.
- Outside CMP, cmp_a and cmp_b drive 0.
- cmp_lt and cmp_gt both high is illegal. If it occurs, GT takes priority.

## Timing
- Reset (rst_n low at an edge) forces:
  - State to IDLE and the last-grant register to 1.
  - done0 = done1 = 0, lt = gt = eq = 0, busy = 0, cmp_a = cmp_b = 0.
- Reset mid-operation discards the operation. No done pulse is issued.
- Request seen in IDLE at cycle t (grant edge ends cycle t):
  - CMP occupies cycles t+1 .. t+n, where n is the number of nibbles examined (1..NIB).
  - done and the result are visible in cycle t+n+1.
  - IDLE is re-entered at t+n+2.
- Minimum request-to-request spacing is n+2 cycles. There is no back-to-back grant out of DONE.
- The comparator path is combinational within one CMP cycle. cmp_lt/cmp_gt are sampled at the end of that cycle.

## Configuration
- CMP_SCHED_EARLY_EXIT_EN defined: CMP exits at the first nibble with cmp_lt or cmp_gt high. Latency varies from 1 to NIB CMP cycles.
- CMP_SCHED_EARLY_EXIT_EN undefined: CMP always scans all NIB nibbles and exits only at idx==0. Latency is fixed at NIB CMP cycles, so done arrives at t+NIB+1. The result is still taken from the first differing nibble.

## Test plan
All scenarios use WIDTH=8 with a behavioural 4-bit comparator model.
- Reset: hold rst_n=0 for 2 cycles while req0=1, then release → all outputs 0 during reset; first grant goes to req0 in the first IDLE cycle after release.
- Early exit on the high nibble: req0 with a0=8'h93, b0=8'h27, early exit enabled → done0 at t+2; gt=1, lt=0, eq=0. With the macro undefined → done0 at t+3, same result.
- Low-nibble decision and equality:
  - req1 with a1=8'h54, b1=8'h58 → done1 at t+3, lt=1.
  - Then a1=b1=8'hA6 → done1 at t+3, eq=1.
- Round-robin: req0 and req1 held high continuously → grants alternate 0,1,0,1 starting with 0; done pulses alternate; each operation is at least 3 cycles apart with early exit disabled.
- Robustness:
  - Drop req0 and change a0 one cycle after grant → the result reflects the latched operands and done0 still pulses.
  - Assert rst_n=0 during CMP → no done pulse, and outputs return to their reset values.
